// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, default widths
// and the response record.
package apb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired flags the cycle whose increment would
// reach LIMIT. Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic pclk,
    input  logic prst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = en && (cnt_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns a one-cycle response pulse. Optional timeout: define APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    apb_state_t state_reg;
    logic       timeout_expired;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk   (pclk),
        .prst_n (prst_n),
        .clr    (state_reg != ACCESS),
        .en     ((state_reg == ACCESS) && !pready),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // ACCESS passes pready through so a new command can chain straight into SETUP.
    always_comb begin
        cmd_ready = 1'b0;
        case (state_reg)
            IDLE:    cmd_ready = 1'b1;
            ACCESS:  cmd_ready = pready;
            default: cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_reg <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= pwrite;
                        rsp_err   <= 1'b0;
                        if (!pwrite) begin
                            rsp_rdata <= prdata;
                        end
                        if (cmd_valid) begin
                            pwrite    <= cmd_write;
                            paddr     <= cmd_addr;
                            pwdata    <= cmd_wdata;
                            penable   <= 1'b0;
                            state_reg <= SETUP;
                        end else begin
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (timeout_expired) begin
                        // Abort: report an error response with zeroed data.
                        rsp_valid <= 1'b1;
                        rsp_write <= pwrite;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a wait-state APB peripheral model,
// expected responses queued at command handshake and checked on rsp_valid.
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    apb_rsp_t    exp_q[$];
    apb_rsp_t    mon_e;
    logic [31:0] ref_mem [64];
    logic [31:0] mem [64];
    int          wait_states = 0;
    int          acc_cnt = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_W(6),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // Peripheral model: pready after wait_states low ACCESS cycles.
    assign pready = psel && penable && (acc_cnt >= wait_states);
    assign prdata = mem[paddr];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (prst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rsp: write=%0b rdata=%08h err=%0b", rsp_write, rsp_rdata, rsp_err);
                check("rsp_write", rsp_write, mon_e.write);
                check("rsp_err", rsp_err, mon_e.err);
                if (!mon_e.write || mon_e.err) check("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic push_exp(input logic w, input logic [5:0] a, input logic [31:0] d, input logic err);
        apb_rsp_t e;
        e.write = w;
        e.err   = err;
        e.rdata = '0;
        if (!err) begin
            if (w) ref_mem[a] = d;
            else   e.rdata = ref_mem[a];
        end
        exp_q.push_back(e);
    endtask

    // Returns #1 after the handshake edge, i.e. inside cycle 1.
    task automatic send(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input bit keep, input logic err);
        int n = 0;
        bit hs = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!hs && n < 50) begin
            @(negedge pclk);
            hs = cmd_ready;
            @(posedge pclk);
            #1;
            n++;
        end
        if (!hs) check("handshake_timeout", 64'd0, 64'd1);
        $display("cmd: write=%0b addr=%02h wdata=%08h", w, a, d);
        push_exp(w, a, d, err);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge pclk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge pclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        prst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #12;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk);
        #1;

        // Single write, zero wait states
        wait_states = 0;
        send(1'b1, 6'h05, 32'hDEADBEEF, 1'b0, 1'b0);
        @(negedge pclk);
        check("w_c1_psel", psel, 1);
        check("w_c1_penable", penable, 0);
        check("w_c1_pwrite", pwrite, 1);
        check("w_c1_paddr", paddr, 6'h05);
        check("w_c1_pwdata", pwdata, 32'hDEADBEEF);
        check("w_c1_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        check("w_c2_psel", psel, 1);
        check("w_c2_penable", penable, 1);
        check("w_c2_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        check("w_c3_rsp_valid", rsp_valid, 1);
        check("w_c3_psel", psel, 0);
        check("w_c3_penable", penable, 0);
        drain();

        // Read with three wait states
        wait_states = 3;
        send(1'b0, 6'h05, 32'h0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge pclk);
            check("r_paddr", paddr, 6'h05);
            check("r_pwrite", pwrite, 0);
            check("r_psel", psel, 1);
            check("r_rsp_valid", rsp_valid, 0);
        end
        @(negedge pclk);
        check("r_c6_rsp_valid", rsp_valid, 1);
        check("r_c6_rdata", rsp_rdata, 32'hDEADBEEF);
        drain();

        // Back-to-back writes
        wait_states = 0;
        send(1'b1, 6'h01, 32'h1111_0001, 1'b1, 1'b0);
        cmd_addr  = 6'h02;
        cmd_wdata = 32'h2222_0002;
        @(negedge pclk);
        check("b2b_c1_psel", psel, 1);
        check("b2b_c1_penable", penable, 0);
        @(negedge pclk);
        check("b2b_c2_psel", psel, 1);
        check("b2b_c2_penable", penable, 1);
        check("b2b_c2_cmd_ready", cmd_ready, 1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd: write=1 addr=02 wdata=22220002");
        push_exp(1'b1, 6'h02, 32'h2222_0002, 1'b0);
        @(negedge pclk);
        check("b2b_c3_psel", psel, 1);
        check("b2b_c3_penable", penable, 0);
        check("b2b_c3_paddr", paddr, 6'h02);
        check("b2b_c3_rsp_valid", rsp_valid, 1);
        @(negedge pclk);
        check("b2b_c4_psel", psel, 1);
        check("b2b_c4_penable", penable, 1);
        check("b2b_c4_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        check("b2b_c5_rsp_valid", rsp_valid, 1);
        check("b2b_c5_psel", psel, 0);
        drain();
        send(1'b0, 6'h01, 32'h0, 1'b0, 1'b0);
        send(1'b0, 6'h02, 32'h0, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a read ACCESS phase
        wait_states = 5;
        send(1'b0, 6'h02, 32'h0, 1'b0, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        check("rst_mid_penable_before", penable, 1);
        #2;
        prst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);
        check("post_rst_psel", psel, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        wait_states = 0;
        @(posedge pclk);
        #1;
        send(1'b0, 6'h01, 32'h0, 1'b0, 1'b0);
        drain();

`ifdef APB_TIMEOUT_EN
        // pready never rises: abort after four ACCESS cycles
        wait_states = 1000;
        send(1'b0, 6'h03, 32'h0, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge pclk);
            check("to_psel", psel, 1);
        end
        @(negedge pclk);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel_after", psel, 0);
        drain();

        // pready rises on the fourth wait cycle: normal completion wins
        wait_states = 3;
        send(1'b0, 6'h02, 32'h0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) @(negedge pclk);
        @(negedge pclk);
        check("to_edge_rsp_valid", rsp_valid, 1);
        check("to_edge_rsp_err", rsp_err, 0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
